// File: rtl/alu_sched_pkg.sv
// Shared types and widths for the ALU scheduler.
//   - state_e  : scheduler FSM states
//   - alu_op_e : opcode map understood by alu_cskpa (the scheduler never decodes it)
//   - cmd_t    : one registered command (opcode + two operands)
package alu_sched_pkg;

    localparam int unsigned OpcodeW  = 4;
    localparam int unsigned OperandW = 32;
    localparam int unsigned ProductW = 64;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    typedef enum logic [3:0] {
        OpAdd   = 4'd0,
        OpSub   = 4'd1,
        OpAnd   = 4'd2,
        OpOr    = 4'd3,
        OpXor   = 4'd4,
        OpNor   = 4'd5,
        OpXnor  = 4'd6,
        OpNot   = 4'd7,
        OpSll   = 4'd8,
        OpSrl   = 4'd9,
        OpSra   = 4'd10,
        OpSlt   = 4'd11,
        OpSltu  = 4'd12,
        OpInc   = 4'd13,
        OpDec   = 4'd14,
        OpPassB = 4'd15
    } alu_op_e;

    typedef struct packed {
        logic [OpcodeW-1:0]  opcode;
        logic [OperandW-1:0] op1;
        logic [OperandW-1:0] op2;
    } cmd_t;

endpackage

// File: rtl/alu_sched_if.sv
// Request/response bundle between two requesters, the scheduler and the consumer.
//   req0_* / req1_* : valid/ready command channels (opcode, op1, op2)
//   rsp_*           : valid/ready response channel (id, result, carry, product)
// Modports: master = requesters + consumer side, slave = scheduler side.
interface alu_sched_if;
    import alu_sched_pkg::*;

    logic                req0_valid;
    logic                req0_ready;
    logic [OpcodeW-1:0]  req0_opcode;
    logic [OperandW-1:0] req0_op1;
    logic [OperandW-1:0] req0_op2;

    logic                req1_valid;
    logic                req1_ready;
    logic [OpcodeW-1:0]  req1_opcode;
    logic [OperandW-1:0] req1_op1;
    logic [OperandW-1:0] req1_op2;

    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [OperandW-1:0] rsp_result;
    logic                rsp_carry;
    logic [ProductW-1:0] rsp_product;

    modport master (
        output req0_valid, req0_opcode, req0_op1, req0_op2,
        output req1_valid, req1_opcode, req1_op1, req1_op2,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_product
    );

    modport slave (
        input  req0_valid, req0_opcode, req0_op1, req0_op2,
        input  req1_valid, req1_opcode, req1_op1, req1_op2,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_product
    );

endinterface

// File: rtl/alu_cskpa.sv
// Combinational 32-bit ALU built around a 4-bit-block carry-skip adder, plus a
// full 32x32->64 unsigned multiplier that is always active.
//   opcode_i    : alu_op_e encoding
//   op1_i/op2_i : operands
//   result_o    : 32-bit result
//   carry_out_o : adder carry-out for add/sub/inc/dec, 0 otherwise
//   product_o   : op1_i * op2_i (unsigned, 64 bits)
module alu_cskpa
    import alu_sched_pkg::*;
(
    input  logic [OpcodeW-1:0]  opcode_i,
    input  logic [OperandW-1:0] op1_i,
    input  logic [OperandW-1:0] op2_i,
    output logic [OperandW-1:0] result_o,
    output logic                carry_out_o,
    output logic [ProductW-1:0] product_o
);

    localparam int unsigned BlkW   = 4;
    localparam int unsigned NumBlk = OperandW / BlkW;

    alu_op_e             op;
    logic [4:0]          shamt;
    logic [OperandW-1:0] add_x, add_y, add_p, add_g, add_sum;
    logic [OperandW:0]   add_c;
    logic                add_cin;

    assign op    = alu_op_e'(opcode_i);
    assign shamt = op2_i[4:0];

    // Sub is a + ~b + 1, so carry-out is the "no borrow" flag; dec adds all-ones.
    always_comb begin
        add_x   = op1_i;
        add_y   = op2_i;
        add_cin = 1'b0;
        case (op)
            OpSub: begin
                add_y   = ~op2_i;
                add_cin = 1'b1;
            end
            OpInc: begin
                add_y   = '0;
                add_cin = 1'b1;
            end
            OpDec: add_y = '1;
            default: ;
        endcase
    end

    // Ripple inside each block; a fully-propagating block forwards its carry-in.
    always_comb begin
        add_p    = add_x ^ add_y;
        add_g    = add_x & add_y;
        add_c    = '0;
        add_c[0] = add_cin;
        for (int blk = 0; blk < NumBlk; blk++) begin
            for (int i = 0; i < BlkW; i++) begin
                add_c[blk*BlkW + i + 1] = add_g[blk*BlkW + i]
                                        | (add_p[blk*BlkW + i] & add_c[blk*BlkW + i]);
            end
            if (&add_p[blk*BlkW +: BlkW]) begin
                add_c[(blk+1)*BlkW] = add_c[blk*BlkW];
            end
        end
        add_sum = add_p ^ add_c[OperandW-1:0];
    end

    always_comb begin
        result_o    = '0;
        carry_out_o = 1'b0;
        unique case (op)
            OpAdd, OpSub, OpInc, OpDec: begin
                result_o    = add_sum;
                carry_out_o = add_c[OperandW];
            end
            OpAnd:   result_o = op1_i & op2_i;
            OpOr:    result_o = op1_i | op2_i;
            OpXor:   result_o = op1_i ^ op2_i;
            OpNor:   result_o = ~(op1_i | op2_i);
            OpXnor:  result_o = ~(op1_i ^ op2_i);
            OpNot:   result_o = ~op1_i;
            OpSll:   result_o = op1_i << shamt;
            OpSrl:   result_o = op1_i >> shamt;
            OpSra:   result_o = $signed(op1_i) >>> shamt;
            OpSlt:   result_o = {{(OperandW-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
            OpSltu:  result_o = {{(OperandW-1){1'b0}}, op1_i < op2_i};
            OpPassB: result_o = op2_i;
            default: result_o = '0;
        endcase
    end

    assign product_o = {{(ProductW-OperandW){1'b0}}, op1_i}
                     * {{(ProductW-OperandW){1'b0}}, op2_i};

endmodule

// File: rtl/alu_sched.sv
// Two-requester scheduler in front of one shared alu_cskpa.
// A command is granted in IDLE, held in registers for EXEC_CYCLES cycles while
// the ALU settles, captured, and presented on the response channel until taken.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_sched_if.slave (req0/req1 command channels, rsp channel)
//   busy_o     : high whenever the FSM is not idle
// Parameter EXEC_CYCLES (1..15): cycles the ALU inputs are held before capture.
// Optional macro ALU_SCHED_RR_EN: round-robin on contention; otherwise
// requester 0 has fixed priority.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_sched_if.slave bus,
    output logic       busy_o
);

    localparam logic [3:0] CntLoad = 4'(EXEC_CYCLES - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                last_q, last_d;
    cmd_t                cmd_q, cmd_d;
    logic                id_q, id_d;
    logic [OperandW-1:0] rsp_result_q, rsp_result_d;
    logic                rsp_carry_q, rsp_carry_d;
    logic [ProductW-1:0] rsp_product_q, rsp_product_d;

    logic                any_valid, grant1, ready0, ready1;
    logic [OperandW-1:0] alu_result;
    logic                alu_carry;
    logic [ProductW-1:0] alu_product;

    assign any_valid = bus.req0_valid | bus.req1_valid;

`ifdef ALU_SCHED_RR_EN
    // On contention the requester that was not granted last wins.
    assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
`else
    assign grant1 = bus.req1_valid & ~bus.req0_valid;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        cmd_d         = cmd_q;
        id_d          = id_q;
        rsp_result_d  = rsp_result_q;
        rsp_carry_d   = rsp_carry_q;
        rsp_product_d = rsp_product_q;
        ready0        = 1'b0;
        ready1        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    ready0  = ~grant1;
                    ready1  = grant1;
                    cmd_d   = grant1 ? '{opcode: bus.req1_opcode, op1: bus.req1_op1,
                                         op2: bus.req1_op2}
                                     : '{opcode: bus.req0_opcode, op1: bus.req0_op1,
                                         op2: bus.req0_op2};
                    id_d    = grant1;
                    last_d  = grant1;
                    cnt_d   = CntLoad;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q == '0) begin
                    rsp_result_d  = alu_result;
                    rsp_carry_d   = alu_carry;
                    rsp_product_d = alu_product;
                    state_d       = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            last_q        <= 1'b1;
            cmd_q         <= '0;
            id_q          <= 1'b0;
            rsp_result_q  <= '0;
            rsp_carry_q   <= 1'b0;
            rsp_product_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            cmd_q         <= cmd_d;
            id_q          <= id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_carry_q   <= rsp_carry_d;
            rsp_product_q <= rsp_product_d;
        end
    end

    // ALU sees only the registered command so its inputs are stable through EXEC.
    alu_cskpa u_alu (
        .opcode_i    (cmd_q.opcode),
        .op1_i       (cmd_q.op1),
        .op2_i       (cmd_q.op2),
        .result_o    (alu_result),
        .carry_out_o (alu_carry),
        .product_o   (alu_product)
    );

    // Ready is combinational from IDLE, so gate it with reset explicitly.
    assign bus.req0_ready  = ready0 & rst_n;
    assign bus.req1_ready  = ready1 & rst_n;
    assign bus.rsp_valid   = (state_q == StResp);
    assign bus.rsp_id      = id_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_carry   = rsp_carry_q;
    assign bus.rsp_product = rsp_product_q;
    assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_alu_sched.sv
// Randomized self-checking bench for alu_sched against a behavioural ALU and
// arbitration model. Main DUT uses EXEC_CYCLES=2; two extra instances cover
// EXEC_CYCLES=1 and 15.
module tb_alu_sched;
    import alu_sched_pkg::*;

    localparam int Exec = 2;
`ifdef ALU_SCHED_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy, busy1, busy15;
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   last_grant = 1;

    logic [3:0]  ref_op = '0;
    logic [31:0] ref_a  = '0;
    logic [31:0] ref_b  = '0;
    logic [31:0] ref_result;
    logic        ref_carry;
    logic [63:0] ref_product;

    alu_sched_if bus ();
    alu_sched_if bus1 ();
    alu_sched_if bus15 ();

    alu_sched #(.EXEC_CYCLES(Exec)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy_o (busy)
    );

    alu_sched #(.EXEC_CYCLES(1)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus1),
        .busy_o (busy1)
    );

    alu_sched #(.EXEC_CYCLES(15)) u_dut15 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus15),
        .busy_o (busy15)
    );

    alu_cskpa u_ref (
        .opcode_i    (ref_op),
        .op1_i       (ref_a),
        .op2_i       (ref_b),
        .result_o    (ref_result),
        .carry_out_o (ref_carry),
        .product_o   (ref_product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Returns {carry, result[31:0], product[63:0]} from plain arithmetic.
    function automatic logic [96:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic [4:0]  sh;
        logic [63:0] p;
        sh = b[4:0];
        r  = '0;
        c  = 1'b0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
            end
            4'd1: begin r = a - b; c = (a >= b); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~(a | b);
            4'd6: r = ~(a ^ b);
            4'd7: r = ~a;
            4'd8: r = a << sh;
            4'd9: r = a >> sh;
            4'd10: r = $signed(a) >>> sh;
            4'd11: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12: r = (a < b) ? 32'd1 : 32'd0;
            4'd13: begin r = a + 32'd1; c = (a == 32'hFFFF_FFFF); end
            4'd14: begin r = a - 32'd1; c = (a != 32'd0); end
            default: r = b;
        endcase
        p = {32'd0, a} * {32'd0, b};
        return {c, r, p};
    endfunction

    // Present one request pattern to the idle main DUT and follow it to completion.
    task automatic do_txn(input bit v0, input bit v1, input logic [3:0] o0,
                          input logic [3:0] o1, input logic [31:0] a0, input logic [31:0] b0,
                          input logic [31:0] a1, input logic [31:0] b1, input int stall,
                          input bit early, input string tag);
        int          w;
        int          k;
        logic [96:0] expv;
        if (v0 && !v1)      w = 0;
        else if (v1 && !v0) w = 1;
        else                w = RrEn ? 1 - last_grant : 0;
        expv   = (w == 0) ? alu_model(o0, a0, b0) : alu_model(o1, a1, b1);
        ref_op = (w == 0) ? o0 : o1;
        ref_a  = (w == 0) ? a0 : a1;
        ref_b  = (w == 0) ? b0 : b1;
        bus.req0_opcode = o0; bus.req0_op1 = a0; bus.req0_op2 = b0;
        bus.req1_opcode = o1; bus.req1_op1 = a1; bus.req1_op2 = b1;
        bus.req0_valid  = v0; bus.req1_valid = v1;
        #1;
        check({tag, " idle ready0"}, 64'(bus.req0_ready), 64'(w == 0));
        check({tag, " idle ready1"}, 64'(bus.req1_ready), 64'(w == 1));
        check({tag, " idle busy"}, 64'(busy), 64'd0);
        last_grant = w;
        @(posedge clk);
        #1;
        bus.rsp_ready = early;
        check({tag, " exec ready0"}, 64'(bus.req0_ready), 64'd0);
        check({tag, " exec ready1"}, 64'(bus.req1_ready), 64'd0);
        check({tag, " exec busy"}, 64'(busy), 64'd1);
        for (k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) break;
        end
        check({tag, " latency"}, 64'(k), 64'(Exec));
        check({tag, " rsp_id"}, 64'(bus.rsp_id), 64'(w));
        check({tag, " result"}, 64'(bus.rsp_result), 64'(expv[95:64]));
        check({tag, " carry"}, 64'(bus.rsp_carry), 64'(expv[96]));
        check({tag, " product"}, bus.rsp_product, expv[63:0]);
        check({tag, " vs ref alu"}, 64'(bus.rsp_result), 64'(ref_result));
        bus.rsp_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            check({tag, " stall valid"}, 64'(bus.rsp_valid), 64'd1);
            check({tag, " stall result"}, 64'(bus.rsp_result), 64'(expv[95:64]));
            check({tag, " stall product"}, bus.rsp_product, expv[63:0]);
            check({tag, " stall ready"}, 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
            check({tag, " stall busy"}, 64'(busy), 64'd1);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check({tag, " done valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, " done busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  ro0, ro1;
        logic [31:0] ra0, rb0, ra1, rb1;
        logic [1:0]  pat;
        logic [96:0] e1, e15;
        int          k1, k15;
        bit          seen;

        bus.req0_valid = 1'b1; bus.req0_opcode = '0; bus.req0_op1 = '0; bus.req0_op2 = '0;
        bus.req1_valid = 1'b1; bus.req1_opcode = '0; bus.req1_op1 = '0; bus.req1_op2 = '0;
        bus.rsp_ready  = 1'b0;
        bus1.req0_valid = 1'b0; bus1.req0_opcode = '0; bus1.req0_op1 = '0; bus1.req0_op2 = '0;
        bus1.req1_valid = 1'b0; bus1.req1_opcode = '0; bus1.req1_op1 = '0; bus1.req1_op2 = '0;
        bus1.rsp_ready  = 1'b0;
        bus15.req0_valid = 1'b0; bus15.req0_opcode = '0; bus15.req0_op1 = '0;
        bus15.req0_op2 = '0; bus15.req1_valid = 1'b0; bus15.req1_opcode = '0;
        bus15.req1_op1 = '0; bus15.req1_op2 = '0; bus15.rsp_ready = 1'b0;

        // Reset with both requesters asserting valid.
        #2 rst_n = 1'b0;
        #10;
        check("reset ready0", 64'(bus.req0_ready), 64'd0);
        check("reset ready1", 64'(bus.req1_ready), 64'd0);
        check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset rsp_id", 64'(bus.rsp_id), 64'd0);
        check("reset result", 64'(bus.rsp_result), 64'd0);
        check("reset product", bus.rsp_product, 64'd0);
        #11 rst_n = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk);
        #1;

        // All opcodes from requester 0 with 8/8 operands.
        for (int op = 0; op < 16; op++) begin
            do_txn(1'b1, 1'b0, 4'(op), 4'd0, 32'd8, 32'd8, 32'd0, 32'd0, 0, 1'b1, "seq");
        end

        // Reset in the middle of EXEC: command dropped, outputs cleared at once.
        bus.req0_opcode = 4'd0; bus.req0_op1 = 32'd5; bus.req0_op2 = 32'd7;
        bus.req0_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midrst rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst rsp_id", 64'(bus.rsp_id), 64'd0);
        check("midrst result", 64'(bus.rsp_result), 64'd0);
        check("midrst carry", 64'(bus.rsp_carry), 64'd0);
        check("midrst product", bus.rsp_product, 64'd0);
        check("midrst ready1", 64'(bus.req1_ready), 64'd0);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        bus.req1_valid = 1'b0;
        last_grant = 1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("midrst no response", 64'(seen), 64'd0);
        do_txn(1'b0, 1'b1, 4'd0, 4'd1, 32'd0, 32'd0, 32'd100, 32'd58, 0, 1'b0, "after rst");

        // Continuous contention: alternate under round-robin, else always 0.
        for (int i = 0; i < 4; i++) begin
            do_txn(1'b1, 1'b1, 4'(i), 4'(i + 4), 32'd3 + 32'(i), 32'd9, 32'd11, 32'd2 + 32'(i),
                   0, 1'b0, "arb");
            check("arb sequence", 64'(bus.rsp_id), RrEn ? 64'(i % 2) : 64'd0);
        end

        // Consumer back-pressure for five cycles.
        do_txn(1'b1, 1'b0, 4'd0, 4'd0, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 32'd0, 5, 1'b0,
               "stall");

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            pat = 2'($urandom_range(1, 3));
            ro0 = 4'($urandom_range(0, 15));
            ro1 = 4'($urandom_range(0, 15));
            ra0 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            rb0 = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
            ra1 = $urandom;
            rb1 = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            do_txn(pat[0], pat[1], ro0, ro1, ra0, rb0, ra1, rb1, int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), "rand");
        end

        // Latency extremes with the all-ones + 1 operand pair.
        for (int t = 0; t < 2; t++) begin
            ro0 = 4'(t);
            e1  = alu_model(ro0, 32'hFFFF_FFFF, 32'h1);
            e15 = e1;
            bus1.req0_opcode  = ro0; bus1.req0_op1  = 32'hFFFF_FFFF; bus1.req0_op2  = 32'h1;
            bus15.req0_opcode = ro0; bus15.req0_op1 = 32'hFFFF_FFFF; bus15.req0_op2 = 32'h1;
            bus1.req0_valid = 1'b1;
            bus15.req0_valid = 1'b1;
            #1;
            check("e1 ready", 64'(bus1.req0_ready), 64'd1);
            check("e15 ready", 64'(bus15.req0_ready), 64'd1);
            @(posedge clk);
            #1;
            bus1.req0_valid = 1'b0;
            bus15.req0_valid = 1'b0;
            k1 = 0;
            k15 = 0;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk);
                #1;
                if (bus1.rsp_valid && k1 == 0) k1 = k;
                if (bus15.rsp_valid && k15 == 0) k15 = k;
            end
            check("e1 latency", 64'(k1), 64'd1);
            check("e15 latency", 64'(k15), 64'd15);
            check("e1 result", 64'(bus1.rsp_result), 64'(e1[95:64]));
            check("e1 carry", 64'(bus1.rsp_carry), 64'(e1[96]));
            check("e1 product", bus1.rsp_product, e1[63:0]);
            check("e15 result", 64'(bus15.rsp_result), 64'(e15[95:64]));
            check("e15 carry", 64'(bus15.rsp_carry), 64'(e15[96]));
            check("e15 product", bus15.rsp_product, e15[63:0]);
            bus1.rsp_ready = 1'b1;
            bus15.rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus1.rsp_ready = 1'b0;
            bus15.rsp_ready = 1'b0;
            check("e1 released", 64'(busy1), 64'd0);
            check("e15 released", 64'(busy15), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter EXEC_CYCLES, default 2, SHALL set the cycles the shared ALU is held stable before result capture (legal 1..15).
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester n presents a command.
REQ-005 req0_ready / req1_ready  output  1  command of requester n accepted this cycle.
REQ-006 req0_opcode / req1_opcode  input  4  ALU opcode, passed through undecoded.
REQ-007 req0_op1, req0_op2 / req1_op1, req1_op2  input  32  ALU operands.
REQ-008 rsp_valid  output  1  response available; rsp_ready  input  1  consumer accepts.
REQ-009 rsp_id  output  1  index of the requester that issued the command.
REQ-010 rsp_result  output  32; rsp_carry  output  1; rsp_product  output  64  captured ALU outputs.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The block SHALL run a 3-state FSM: IDLE, EXEC, RESP.
REQ-013 IDLE: if any reqn_valid, grant one requester, assert only its reqn_ready combinationally, register opcode/op1/op2 and id, load the exec counter with EXEC_CYCLES-1, go to EXEC.
REQ-014 reqn_ready SHALL be 0 in EXEC and RESP, and 0 for the non-granted requester.
REQ-015 EXEC: the alu_cskpa instance SHALL be driven only from the registered command; counter decrements each cycle; at count 0, capture result/carry_out/product into rsp registers and go to RESP.
REQ-016 RESP: rsp_valid=1 with all rsp_* stable until rsp_ready=1; on that handshake go to IDLE.
REQ-017 Latency: command accepted at edge T SHALL give rsp_valid high from edge T+EXEC_CYCLES; the next command is accepted no earlier than the cycle after the response handshake.
REQ-018 Arbitration: one valid SHALL always win; both valid SHALL grant per REQ-025; a requester dropping valid before grant is never served.
REQ-019 The arbitration pointer (last granted id) SHALL update only on an accepted command.
REQ-020 All 16 opcodes SHALL be forwarded unmodified; widths are fixed at 32/32/64 with no truncation.
REQ-021 rsp_ready while rsp_valid=0 SHALL have no effect.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_product=0, busy=0, counter=0, last-grant pointer=1, and zero the command registers.
REQ-023 Reset asserted in EXEC or RESP SHALL discard the in-flight command with no response.
REQ-024 reqn_ready SHALL be 0 while rst_n is low.

Configuration
REQ-025 With ALU_SCHED_RR_EN defined, simultaneous requests SHALL be granted round-robin (the requester not last granted wins; first contention after reset goes to requester 0); without it, requester 0 SHALL always win contention.

Structure
REQ-026 A shared package alu_sched_pkg SHALL hold the state enum (IDLE/EXEC/RESP), opcode width 4, operand width 32, product width 64.
REQ-027 The only sub-module SHALL be one alu_cskpa instance; arbitration and FSM are inline.

Verification
REQ-028 req0 only, opcode 0..15 sequentially, op1=8, op2=8, rsp_ready=1 -> each rsp matches a free-standing alu_cskpa driven with the same inputs, rsp_id=0, rsp_valid exactly EXEC_CYCLES cycles after accept.
REQ-029 Both valid continuously, RR_EN defined -> grants alternate 0,1,0,1; RR_EN undefined -> four grants all to 0.
REQ-030 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, both reqn_ready=0, busy=1; accept resumes the cycle after rsp_ready=1.
REQ-031 rst_n pulsed low mid-EXEC -> all outputs zero asynchronously, no rsp_valid for that command, next req1 command served normally.
REQ-032 EXEC_CYCLES=1 and 15, op1=32'hFFFFFFFF, op2=32'h1 -> rsp_valid at exactly T+1 and T+15, captured values match reference instance including carry and 64-bit product.
